// File: rtl/board_cell_streamer.sv
// Snapshots the 4x4 game board and streams it one cell per beat over valid/ready,
// re-streaming on board change or refresh and publishing per-frame max/empty stats.
module board_cell_streamer #(
  parameter int RANGE = 4,
  parameter int CELLS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RANGE*CELLS-1:0]   board,
  input  logic                     refresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               cell_idx,
  output logic [RANGE-1:0]         cell_val,
  output logic                     cell_empty,
  output logic                     sof,
  output logic                     eof,
  output logic                     busy,
  output logic                     frame_done,
  output logic [RANGE-1:0]         max_exp,
  output logic [4:0]               empty_count,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [RANGE*CELLS-1:0]   snapshot_q;
  logic                     pending_q, pending_d;
  logic [3:0]               idx_q;
  logic [RANGE-1:0]         acc_max_q;
  logic [4:0]               acc_empty_q;
  logic [RANGE-1:0]         max_exp_q;
  logic [4:0]               empty_count_q;
  logic                     xfer;
  logic                     last_cell;

  // Handshake: a beat transfers on a rising edge where out_valid and out_ready are
  // both high; once out_valid rises it stays high with a stable payload until the
  // eof beat transfers.
  assign out_valid  = (state_q == STREAM);
  assign xfer       = out_valid & out_ready;
  assign last_cell  = (idx_q == 4'(CELLS - 1));

  assign cell_idx   = idx_q;
  assign cell_val   = snapshot_q[RANGE*int'(idx_q) +: RANGE];
  assign cell_empty = (cell_val == '0);
  assign sof        = (idx_q == 4'd0);
  assign eof        = last_cell;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign max_exp     = max_exp_q;
  assign empty_count = empty_count_q;
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if ((board != snapshot_q) || pending_q) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (xfer && last_cell) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A refresh arriving in the same cycle as the LOAD entry must survive, so it wins.
  always_comb begin
    pending_d = pending_q;
    if (refresh)
      pending_d = 1'b1;
    else if (state_q == IDLE && state_d == LOAD)
      pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot_q    <= '0;
      idx_q         <= '0;
      acc_max_q     <= '0;
      acc_empty_q   <= '0;
      max_exp_q     <= '0;
      empty_count_q <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          snapshot_q  <= board;
          idx_q       <= '0;
          acc_max_q   <= '0;
          acc_empty_q <= '0;
        end
        STREAM: begin
          if (xfer) begin
            if (cell_val > acc_max_q) acc_max_q <= cell_val;
            acc_empty_q <= acc_empty_q + 5'(cell_empty);
            idx_q       <= idx_q + 4'd1;
          end
        end
        DONE: begin
          max_exp_q     <= acc_max_q;
          empty_count_q <= acc_empty_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_cell_streamer.sv
// Randomized bench for board_cell_streamer: a frame-level model predicts which
// boards get streamed and their statistics; a negedge monitor checks every beat.
module tb_board_cell_streamer;

  logic        clk;
  logic        rst;
  logic [63:0] board;
  logic        refresh;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  cell_idx;
  logic [3:0]  cell_val;
  logic        cell_empty;
  logic        sof;
  logic        eof;
  logic        busy;
  logic        frame_done;
  logic [3:0]  max_exp;
  logic [4:0]  empty_count;
  logic [1:0]  state_dbg;

  board_cell_streamer #(.RANGE(4), .CELLS(16)) dut (
    .clk(clk), .rst(rst), .board(board), .refresh(refresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .cell_idx(cell_idx), .cell_val(cell_val), .cell_empty(cell_empty),
    .sof(sof), .eof(eof), .busy(busy), .frame_done(frame_done),
    .max_exp(max_exp), .empty_count(empty_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // model / scoreboard: queue of boards expected to be streamed, in order
  logic [63:0] exp_q[$];

  function automatic void frame_stats(input logic [63:0] f, output int mx, output int ne);
    int v;
    mx = 0;
    ne = 0;
    for (int i = 0; i < 16; i++) begin
      v = int'(f[4*i +: 4]);
      if (v > mx) mx = v;
      if (v == 0) ne++;
    end
  endfunction

  function automatic logic [63:0] rand_board(input int lo, input int hi);
    logic [63:0] b;
    for (int i = 0; i < 16; i++) b[4*i +: 4] = 4'($urandom_range(hi, lo));
    return b;
  endfunction

  // out_ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  int ready_mode = 0;
  int ready_ctr  = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(1, 0));
        2:       out_ready = (ready_ctr % 3 == 0);
        default: out_ready = 1'b1;
      endcase
      ready_ctr++;
    end
  end

  // monitor
  logic [63:0] cur;
  int          beat_n;
  bit          in_frame, expect_done, stats_due, prev_stall;
  logic [3:0]  prev_idx, prev_val;
  int          due_max, due_empty, last_max, last_empty;

  initial begin
    beat_n = 0; in_frame = 0; expect_done = 0; stats_due = 0; prev_stall = 0;
    last_max = 0; last_empty = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        beat_n = 0; in_frame = 0; expect_done = 0; stats_due = 0; prev_stall = 0;
        last_max = 0; last_empty = 0;
        continue;
      end
      if (stats_due) begin
        check("max_exp", 64'(max_exp), 64'(due_max));
        check("empty_count", 64'(empty_count), 64'(due_empty));
        last_max = due_max;
        last_empty = due_empty;
        stats_due = 0;
      end
      if (frame_done || expect_done) begin
        check("frame_done", 64'(frame_done), 64'(expect_done));
        if (expect_done) stats_due = 1;
        expect_done = 0;
      end
      if (in_frame) check("valid_cont", 64'(out_valid), 64'd1);
      if (out_valid && !in_frame) begin
        check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("stats_hold_max", 64'(max_exp), 64'(last_max));
        check("stats_hold_empty", 64'(empty_count), 64'(last_empty));
        in_frame = 1;
        beat_n = 0;
        prev_stall = 0;
      end
      if (out_valid && in_frame) begin
        if (prev_stall) begin
          check("hold_idx", 64'(cell_idx), 64'(prev_idx));
          check("hold_val", 64'(cell_val), 64'(prev_val));
        end
        check("cell_idx", 64'(cell_idx), 64'(beat_n));
        check("cell_val", 64'(cell_val), 64'(cur[4*beat_n +: 4]));
        check("cell_empty", 64'(cell_empty), 64'(cur[4*beat_n +: 4] == 4'd0));
        check("sof", 64'(sof), 64'(beat_n == 0));
        check("eof", 64'(eof), 64'(beat_n == 15));
        check("busy", 64'(busy), 64'd1);
        prev_stall = !out_ready;
        prev_idx = cell_idx;
        prev_val = cell_val;
        if (out_ready) begin
          if (beat_n == 15) begin
            in_frame = 0;
            expect_done = 1;
            frame_stats(cur, due_max, due_empty);
            beat_n = 0;
          end else begin
            beat_n++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !stats_due && !expect_done) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
    end
    check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_beat(input int k);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (out_valid && int'(cell_idx) == k) return;
    end
    check("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_refresh();
    #1 refresh = 1'b1;
    @(negedge clk);
    #1 refresh = 1'b0;
  endtask

  task automatic new_board(input logic [63:0] b);
    #1 board = b;
    exp_q.push_back(b);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("lat_load_valid", 64'(out_valid), 64'd0);
    check("lat_load_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_first_valid", 64'(out_valid), 64'd1);
  endtask

  logic [63:0] b, b2;
  int          pos;

  initial begin
    rst = 1'b1;
    refresh = 1'b0;
    board = 64'h11;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_max", 64'(max_exp), 64'd0);
    check("rst_empty", 64'(empty_count), 64'd0);
    exp_q.push_back(64'h11);
    release_reset();
    wait_idle();
    check("first_max", 64'(max_exp), 64'd1);
    check("first_empty", 64'(empty_count), 64'd14);
    repeat (30) @(negedge clk);

    // backpressure 1,0,0
    ready_mode = 2;
    do b = rand_board(0, 11); while (b == board);
    new_board(b);
    wait_idle();

    // board change mid-stream
    ready_mode = 0;
    do begin
      b = rand_board(0, 3);
      b[4*5 +: 4] = 4'd0;
    end while (b == board);
    new_board(b);
    wait_beat(8);
    b2 = b;
    b2[4*5 +: 4] = 4'd3;
    new_board(b2);
    wait_idle();
    check("midchg_max", 64'(max_exp), 64'd3);

    // two refresh pulses during one frame give exactly one extra frame
    ready_mode = 1;
    do b = rand_board(0, 9); while (b == board);
    new_board(b);
    exp_q.push_back(b);
    wait_beat(3);
    pulse_refresh();
    wait_beat(10);
    pulse_refresh();
    wait_idle();

    // win tile
    ready_mode = 0;
    b = rand_board(1, 10);
    pos = $urandom_range(15, 0);
    b[4*pos +: 4] = 4'd11;
    new_board(b);
    wait_idle();
    check("win_max", 64'(max_exp), 64'd11);
    check("win_empty", 64'(empty_count), 64'd0);

    // random frames, some triggered by refresh alone
    for (int n = 0; n < 8; n++) begin
      ready_mode = $urandom_range(2, 0);
      if ($urandom_range(3, 0) == 0) begin
        exp_q.push_back(board);
        @(negedge clk);
        pulse_refresh();
      end else begin
        do b = rand_board(0, 11); while (b == board);
        new_board(b);
      end
      wait_idle();
    end

    // reset mid-frame
    ready_mode = 1;
    do b = rand_board(1, 6); while (b == board);
    new_board(b);
    wait_beat(7);
    #1 rst = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(frame_done), 64'd0);
    check("async_max", 64'(max_exp), 64'd0);
    check("async_empty", 64'(empty_count), 64'd0);
    exp_q.delete();
    exp_q.push_back(board);
    repeat (2) @(negedge clk);
    ready_mode = 0;
    release_reset();
    wait_idle();

    repeat (40) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
